// File: rtl/debug_pkg.sv
// debug_pkg: shared types and constants for the debug step controller.
// Holds the FSM state enum and active-low gfedcba seven-segment codes.
package debug_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stable-level debouncer and a
// one-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync0;
  logic          sync1;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // two-stage synchronizer for the asynchronous button
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= btn;
      sync1 <= sync0;
    end
  end

  // accept a new level only after it has held for the full window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync1 == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt   <= '0;
      level <= sync1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // delayed copy of the level for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) level_d <= 1'b0;
    else        level_d <= level;
  end

  assign pulse = level & ~level_d;

endmodule

// File: rtl/debug_step_ctrl.sv
// debug_step_ctrl: run/halt/single-step clock-enable control plus hex display.
// Optional breakpoint comparator is built only when DEBUG_BP_EN is defined.
module debug_step_ctrl
  import debug_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int DATA_W          = 32,
  parameter int NUM_DIGITS      = 6,
  parameter int DEBOUNCE_CYCLES = 50000,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     debug,
  input  logic                     step_btn,
  input  logic [SEL_W-1:0]         ch_sel,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [31:0]              pc,
  input  logic [31:0]              bp_addr,
  input  logic                     bp_valid,
  output logic                     clk_en,
  output logic                     halted,
  output logic [15:0]              step_count,
  output logic [NUM_DIGITS*7-1:0]  display
);

  state_e                  state_q;
  state_e                  state_d;
  logic                    step_pulse;
  logic                    bp_hit;
  logic                    clk_en_q;
  logic                    halted_q;
  logic [15:0]             step_count_q;
  logic [15:0]             step_count_d;
  logic [DATA_W-1:0]       word;
  logic                    sel_ok;
  logic [NUM_DIGITS*7-1:0] seg_d;
  logic [NUM_DIGITS*7-1:0] display_q;
  logic                    unused_word;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .btn  (step_btn),
    .pulse(step_pulse)
  );

`ifdef DEBUG_BP_EN
  logic bp_armed_q;

  assign bp_hit = bp_valid && bp_armed_q && (pc == bp_addr);

  // disarm on leaving HALT, re-arm once the PC moves off the breakpoint
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bp_armed_q <= 1'b1;
    end else if (state_q == ST_HALT && state_d != ST_HALT) begin
      bp_armed_q <= 1'b0;
    end else if (pc != bp_addr) begin
      bp_armed_q <= 1'b1;
    end
  end
`else
  logic unused_bp;

  assign bp_hit    = 1'b0;
  assign unused_bp = ^{pc, bp_addr, bp_valid};
`endif

  // next state and step counter; steps only leave HALT while debug holds
  always_comb begin
    state_d      = state_q;
    step_count_d = step_count_q;
    unique case (state_q)
      ST_RUN: begin
        if (debug || bp_hit) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (!debug) begin
          state_d = ST_RUN;
        end else if (step_pulse) begin
          state_d      = ST_STEP;
          step_count_d = step_count_q + 16'd1;
        end
      end
      ST_STEP: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  // state, registered enables and step counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      clk_en_q     <= 1'b1;
      halted_q     <= 1'b0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      clk_en_q     <= (state_d != ST_HALT);
      halted_q     <= (state_d == ST_HALT);
      step_count_q <= step_count_d;
    end
  end

  // channel select mux
  always_comb begin
    word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (32'(ch_sel) == k) word = ch_data[k*DATA_W +: DATA_W];
    end
  end

  assign sel_ok      = (32'(ch_sel) < NUM_CH);
  assign unused_word = ^word;

  // per-digit hex encode, dashes for an out-of-range channel
  always_comb begin
    seg_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seg_d[i*7 +: 7] = sel_ok ? HEX_SEG[word[i*4 +: 4]] : SEG_DASH;
    end
  end

  // display register, refreshed every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) display_q <= {NUM_DIGITS{SEG_BLANK}};
    else        display_q <= seg_d;
  end

  assign clk_en     = clk_en_q;
  assign halted     = halted_q;
  assign step_count = step_count_q;
  assign display    = display_q;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// tb_debug_step_ctrl: directed scoreboard bench for debug_step_ctrl.
// Breakpoint checks follow DEBUG_BP_EN when it is defined for the build.
module tb_debug_step_ctrl;

  localparam int NUM_CH = 5;
  localparam int DATA_W = 32;
  localparam int NUM_DIGITS = 6;
  localparam int DEB = 4;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     debug = 1'b0;
  logic                     step_btn = 1'b0;
  logic [2:0]               ch_sel = '0;
  logic [NUM_CH*DATA_W-1:0] ch_data = '0;
  logic [31:0]              pc = '0;
  logic [31:0]              bp_addr = 32'h40;
  logic                     bp_valid = 1'b1;
  logic                     clk_en;
  logic                     halted;
  logic [15:0]              step_count;
  logic [NUM_DIGITS*7-1:0]  display;

  int          passed = 0;
  int          total = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  debug_step_ctrl #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .NUM_DIGITS(NUM_DIGITS),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .debug(debug),
    .step_btn(step_btn),
    .ch_sel(ch_sel),
    .ch_data(ch_data),
    .pc(pc),
    .bp_addr(bp_addr),
    .bp_valid(bp_valid),
    .clk_en(clk_en),
    .halted(halted),
    .step_count(step_count),
    .display(display)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] exp;
    if (exp_q.size() == 0) exp = 'x;
    else exp = exp_q.pop_front();
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // press for 10 cycles, release for 10, counting enabled cycles
  task automatic press(output int n);
    n = 0;
    step_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (clk_en) n++;
    end
    step_btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (clk_en) n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic        found;
    logic        hit;
    logic        en;
    logic        en_at_hit;
    logic [31:0] hit_pc;

    cyc();
    cyc();
    push(64'd1);             check("rst_clk_en", clk_en);
    push(64'd0);             check("rst_halted", halted);
    push(64'd0);             check("rst_count", step_count);
    push({6{7'h7F}});        check("rst_display", display);

    debug = 1'b1;
    reset = 1'b1;
    cyc();
    push(64'd1);             check("first_edge_halted", halted);
    push(64'd0);             check("first_edge_clk_en", clk_en);
    push({6{7'h40}});        check("disp_zeros", display);

    ch_data[2*DATA_W +: DATA_W] = 32'h00AB_CDEF;
    ch_sel = 3'd2;
    push({6{7'h40}});        check("disp_latency", display);
    cyc();
    push({7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E});
    check("disp_abcdef", display);

    ch_data[4*DATA_W +: DATA_W] = 32'h0012_3456;
    ch_sel = 3'd4;
    cyc();
    push({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
    check("disp_123456", display);

    ch_sel = 3'd5;
    cyc();
    push({6{7'h3F}});        check("disp_dash", display);

    press(n);
    push(64'd1);             check("step_en_cycles", n);
    push(64'd1);             check("step_count_1", step_count);
    push(64'd1);             check("step_back_halt", halted);

    n = 0;
    for (int i = 0; i < 10; i++) begin
      step_btn = ~step_btn;
      cyc();
      if (clk_en) n++;
      cyc();
      if (clk_en) n++;
    end
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (clk_en) n++;
    end
    push(64'd0);             check("bounce_en_cycles", n);
    push(64'd1);             check("bounce_count", step_count);

    debug = 1'b0;
    cyc();
    push(64'd0);             check("run_halted", halted);
    press(n);
    push(64'd1);             check("run_discard_count", step_count);
    push(64'd1);             check("run_clk_en", clk_en);
    debug = 1'b1;
    cyc();
    push(64'd1);             check("rehalt", halted);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (clk_en) n++;
    end
    push(64'd0);             check("no_queued_step", n);

    force dut.step_count_q = 16'hFFFF;
    cyc();
    cyc();
    release dut.step_count_q;
    cyc();
    push(64'hFFFF);          check("preload", step_count);
    press(n);
    push(64'd1);             check("wrap_en_cycles", n);
    push(64'd0);             check("wrap_count", step_count);

    found = 1'b0;
    step_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (clk_en) begin
        found = 1'b1;
        break;
      end
    end
    #2;
    reset = 1'b0;
    #1;
    push(64'd1);             check("step_seen", found);
    push(64'd1);             check("midstep_clk_en", clk_en);
    push(64'd0);             check("midstep_halted", halted);
    push(64'd0);             check("midstep_count", step_count);
    step_btn = 1'b0;

    debug = 1'b0;
    pc = '0;
    cyc();
    cyc();
    reset = 1'b1;
    hit = 1'b0;
    hit_pc = '0;
    en_at_hit = 1'b1;
    for (int i = 0; i < 40 && !hit; i++) begin
      en = clk_en;
      cyc();
      if (en) pc = pc + 32'd4;
      if (halted) begin
        hit = 1'b1;
        hit_pc = pc;
        en_at_hit = clk_en;
        debug = 1'b1;
      end
    end
`ifdef DEBUG_BP_EN
    push(64'd1);             check("bp_hit", hit);
    push(64'h44);            check("bp_pc", hit_pc);
    push(64'd0);             check("bp_clk_en", en_at_hit);
`else
    push(64'd0);             check("bp_ignored", hit);
`endif
    cyc();
    cyc();
    debug = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      en = clk_en;
      cyc();
      if (en) pc = pc + 32'd4;
      if (halted) n++;
    end
    push(64'd0);             check("resume_no_trap", n);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
